instr_fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle-style MIPS datapath: it owns the program counter and drives word-aligned byte addresses into the instruction memory over a req/ack handshake. It captures each returned instruction into a one-entry output register with a valid/ready handshake toward the decode/register-bank stage. It also accepts branch/jump redirects from downstream and squashes any fetch that the redirect has made stale.

---
 rtl/instr_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// MIPS instruction fetch stage. It owns the program counter and issues
// word-aligned fetches to instruction memory over a req/ack handshake. Each
// returned word is captured in a one-entry output buffer that is handed to
// decode over a valid/ready handshake. Downstream branch/jump redirects
// override everything else. A request that a redirect has made stale is
// either completed and discarded (DROP) or dropped outright when the
// redirect target is misaligned, which halts the unit until reset.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   imem_req/addr     fetch request and word-aligned byte address (registered)
//   imem_ack/rdata    memory completion and instruction word
//   redirect_valid/pc one-cycle redirect pulse and target address
//   out_valid/ready   output handshake toward decode
//   out_instr/pc/pc_plus4  buffered instruction, its address, address + 4
//   fault             sticky flag: a misaligned redirect was received
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DROP  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        req_q, req_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc_plus4_q, out_pc_plus4_d;
    logic        fault_q, fault_d;

    logic [31:0] req_addr_plus4_s;
    logic        redirect_s;
    logic        misaligned_s;

    // Wraps modulo 2^32 by construction.
    assign req_addr_plus4_s = req_addr_q + 32'd4;
    // HALT ignores redirects entirely.
    assign redirect_s       = redirect_valid && (state_q != ST_HALT);
    assign misaligned_s     = (redirect_pc[1:0] != 2'b00);

    // Next-state and datapath decode; redirect is evaluated ahead of the normal flow.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_addr_d     = req_addr_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;
        fault_d        = fault_q;

        if (redirect_s) begin
            // Any buffered instruction is squashed, even if out_ready is high.
            out_valid_d = 1'b0;
            if (misaligned_s) begin
                // Outstanding request is abandoned; req drops with HALT.
                fault_d = 1'b1;
                state_d = ST_HALT;
            end else begin
                pc_d = redirect_pc;
                case (state_q)
                    ST_FETCH, ST_DROP: begin
                        if (imem_ack) begin
                            // Stale data completes this cycle: go straight to the target.
                            req_addr_d = redirect_pc;
                            state_d    = ST_FETCH;
                        end else begin
                            // Keep the stale address on the bus until memory acks it.
                            state_d = ST_DROP;
                        end
                    end
                    default: begin
                        req_addr_d = redirect_pc;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_addr_d = pc_q;
                    state_d    = ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        out_instr_d    = imem_rdata;
                        out_pc_d       = req_addr_q;
                        out_pc_plus4_d = req_addr_plus4_s;
                        out_valid_d    = 1'b1;
                        pc_d           = req_addr_plus4_s;
                        state_d        = ST_HOLD;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        req_addr_d  = pc_q;
                        state_d     = ST_FETCH;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        req_addr_d = pc_q;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Request line is a function of the next registered state only.
        req_d = (state_d == ST_FETCH) || (state_d == ST_DROP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC;
            req_addr_q     <= RESET_PC;
            req_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_instr_q    <= 32'h0000_0000;
            out_pc_q       <= 32'h0000_0000;
            out_pc_plus4_q <= 32'h0000_0000;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_addr_q     <= req_addr_d;
            req_q          <= req_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
            fault_q        <= fault_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = req_addr_q;
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus4 = out_pc_plus4_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A cycle-by-cycle vector table drives
// rst_n, redirect, imem_ack/rdata and out_ready and lists the outputs expected
// after each rising edge. A second instance with RESET_PC = 32'hFFFF_FFFC is
// exercised by a short hand-written sequence for the address wrap.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] M0 = 32'h2008_0001;
    localparam logic [31:0] M1 = 32'h2009_0002;
    localparam logic [31:0] M2 = 32'h0109_5020;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic        req0, valid0, fault0;
    logic [31:0] addr0, instr0, pc0, p40;
    logic        req1, valid1, fault1;
    logic [31:0] addr1, instr1, pc1, p41;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req0), .imem_addr(addr0),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(valid0), .out_ready(out_ready),
        .out_instr(instr0), .out_pc(pc0), .out_pc_plus4(p40),
        .fault(fault0)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req1), .imem_addr(addr1),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(valid1), .out_ready(out_ready),
        .out_instr(instr1), .out_pc(pc1), .out_pc_plus4(p41),
        .fault(fault1)
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic ack, input logic [31:0] rdata, input logic ready,
                                input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic e_fault);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.ack = ack; v.rdata = rdata;
        v.ready = ready; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc,
                         input logic ack, input logic [31:0] rdata, input logic ready);
        @(negedge clk);
        rst_n          = ~rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_ack       = ack;
        imem_rdata     = rdata;
        out_ready      = ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Zero-wait stream of three instructions.
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, M0,    1'b1, 1'b0, 32'h0, 1'b1, 32'h0, M0,    1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, M1,    1'b1, 1'b0, 32'h4, 1'b1, 32'h4, M1,    1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, M2,    1'b1, 1'b0, 32'h8, 1'b1, 32'h8, M2,    1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0, 1'b0));
        // Reset in the middle of a request, then backpressure on the first instruction.
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, M0,    1'b0, 1'b0, 32'h0, 1'b1, 32'h0, M0,    1'b0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, M0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0));
        // Wait-state fetch at 8, redirected to 0x40 in the first wait cycle.
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, M1,    1'b1, 1'b0, 32'h4,  1'b1, 32'h4, M1,    1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b1, 32'h8,  1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8,  1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b1, 32'h8,  1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b1, 32'h8,  1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 32'h1234_5678, 1'b0));
        // Redirect to 0x100 in HOLD (out_pc=4) with out_ready high in the same cycle.
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b1, M0,    1'b0, 1'b0, 32'h0,   1'b1, 32'h0, M0,    1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 32'h4,   1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b1, M1,    1'b0, 1'b0, 32'h4,   1'b1, 32'h4, M1,    1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 32'hAAAA_0001, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 1'b0));
        // Misaligned redirect halts; later redirect and acks are ignored; reset recovers.
        vecs.push_back(mk(1'b0, 1'b1, 32'h42, 1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 1'b0, 32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 32'h80, 1'b1, 32'h0, 1'b1, 1'b0, 32'h104, 1'b0, 32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h0, 1'b1, 1'b0, 32'h104, 1'b0, 32'h0, 32'h0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, M0,    1'b1, 1'b0, 32'h0,   1'b1, 32'h0, M0,    1'b0));

        // Initial reset and reset-value checks.
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset imem_req",     {31'h0, req0},   32'h0);
        chk("reset imem_addr",    addr0,           32'h0);
        chk("reset out_valid",    {31'h0, valid0}, 32'h0);
        chk("reset out_instr",    instr0,          32'h0);
        chk("reset out_pc",       pc0,             32'h0);
        chk("reset out_pc_plus4", p40,             32'h0);
        chk("reset fault",        {31'h0, fault0}, 32'h0);
        chk("reset addr (wrap inst)", addr1,       32'hFFFF_FFFC);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata, vecs[i].ready);
            chk($sformatf("v%0d imem_req", i),  {31'h0, req0},   {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d imem_addr", i), addr0,           vecs[i].e_addr);
            chk($sformatf("v%0d out_valid", i), {31'h0, valid0}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d fault", i),     {31'h0, fault0}, {31'h0, vecs[i].e_fault});
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d out_pc", i),       pc0,    vecs[i].e_pc);
                chk($sformatf("v%0d out_pc_plus4", i), p40,    vecs[i].e_pc + 32'd4);
                chk($sformatf("v%0d out_instr", i),    instr0, vecs[i].e_instr);
            end
        end

        // Address wrap on the RESET_PC = 0xFFFFFFFC instance.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("wrap reset addr", addr1, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("wrap first req",  {31'h0, req1}, 32'h1);
        chk("wrap first addr", addr1, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0, 1'b1, M0, 1'b1);
        chk("wrap out_valid 1",    {31'h0, valid1}, 32'h1);
        chk("wrap out_pc 1",       pc1,    32'hFFFF_FFFC);
        chk("wrap out_pc_plus4 1", p41,    32'h0000_0000);
        chk("wrap out_instr 1",    instr1, M0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("wrap second addr", addr1, 32'h0000_0000);
        drive(1'b0, 1'b0, 32'h0, 1'b1, M1, 1'b1);
        chk("wrap out_pc 2",       pc1,    32'h0000_0000);
        chk("wrap out_pc_plus4 2", p41,    32'h0000_0004);
        chk("wrap out_instr 2",    instr1, M1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
